histogram_builder_fsm: RTL and testbench

Per-pixel coarse time-of-flight histogram builder for the dToF SiFH pipeline. It sits downstream of the TDC sample stream.
- It accepts one Np-bit timestamp per enabled cycle, in a fixed round-robin order over shots, pixels and events.
- It accumulates one coarse histogram per pixel over one acquisition.
- At the end of each acquisition it publishes each pixel's peak-bin timestamp on peakResult.

---
 rtl/histogram_builder_fsm_pkg.sv | 30 +++
 rtl/histogram_builder_fsm_if.sv | 11 +
 rtl/histogram_builder_fsm_pixel_hist.sv | 47 ++++
 rtl/histogram_builder_fsm.sv | 97 +++++++++
 tb/tb_histogram_builder_fsm.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_builder_fsm_pkg.sv
// Shared constants, state type and helpers for the coarse ToF histogram builder.
package histogram_builder_fsm_pkg;

  // Index widths never drop below one bit, so a size-1 dimension still gets a counter.
  function automatic int unsigned clogMin1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NP                = 10;
  localparam int unsigned PIXEL_NUM_PER_RAM = 3;
  localparam int unsigned EVENTS_PER_PIXEL  = 2;
  localparam int unsigned SHOTS_PER_ACQ     = 2;
  localparam int unsigned BIN_SHIFT         = 5;
  localparam int unsigned CNT_W             = 8;

  localparam int unsigned BIN_W    = NP - BIN_SHIFT;
  localparam int unsigned NUM_BINS = 1 << BIN_W;
  localparam int unsigned PIX_W    = clogMin1(PIXEL_NUM_PER_RAM);
  localparam int unsigned EVT_W    = clogMin1(EVENTS_PER_PIXEL);
  localparam int unsigned SHOT_W   = clogMin1(SHOTS_PER_ACQ);

  localparam logic [NP-1:0] NO_PHOTON = {NP{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

endpackage

// File: rtl/histogram_builder_fsm_if.sv
// Sample stream in, per-pixel peak timestamps out.
interface histogram_builder_fsm_if;
  import histogram_builder_fsm_pkg::*;

  logic          wrEn;
  logic [NP-1:0] data;
  logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM];

  modport master (output wrEn, output data, input peakResult);
  modport slave  (input wrEn, input data, output peakResult);
endinterface

// File: rtl/histogram_builder_fsm_pixel_hist.sv
// One pixel's coarse histogram: saturating bin counters plus running peak tracker.
module his_pixel_hist
  import histogram_builder_fsm_pkg::*;
#(
  parameter int unsigned cntW = CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             sampleEn,
  input  logic [BIN_W-1:0] bin,
  input  logic             isMarker,
  input  logic             clear,
  output logic [BIN_W-1:0] peakBin
);

  logic [cntW-1:0] hist [NUM_BINS];
  logic [cntW-1:0] maxCnt;
  logic [cntW-1:0] curCnt;
  logic [cntW-1:0] newCnt;
  logic            countIt;

  always_comb begin
    curCnt  = hist[bin];
    newCnt  = (curCnt == {cntW{1'b1}}) ? curCnt : curCnt + cntW'(1);
    countIt = sampleEn && !isMarker;
  end

  // Strictly-greater update keeps the earliest bin on ties and after saturation.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int b = 0; b < int'(NUM_BINS); b++) hist[b] <= '0;
      maxCnt  <= '0;
      peakBin <= '0;
    end else if (clear) begin
      for (int b = 0; b < int'(NUM_BINS); b++) hist[b] <= '0;
      maxCnt  <= '0;
      peakBin <= '0;
    end else if (countIt) begin
      hist[bin] <= newCnt;
      if (newCnt > maxCnt) begin
        maxCnt  <= newCnt;
        peakBin <= bin;
      end
    end
  end

endmodule

// File: rtl/histogram_builder_fsm.sv
// Per-pixel coarse time-of-flight histogram builder: sequences samples over
// shots/pixels/events and publishes each pixel's peak bin once per acquisition.
module histogram_builder_fsm
  import histogram_builder_fsm_pkg::*;
#(
  parameter int unsigned cntW = CNT_W
) (
  input logic               clk,
  input logic               res,
  histogram_builder_fsm_if.slave bus
);

  state_e            state;
  state_e            stateNext;
  logic [SHOT_W-1:0] shotIdx;
  logic [PIX_W-1:0]  pixIdx;
  logic [EVT_W-1:0]  evtIdx;
  logic              accept;
  logic              evtLast;
  logic              pixLast;
  logic              shotLast;
  logic              lastSample;
  logic              publish;
  logic [BIN_W-1:0]  sampleBin;
  logic              isMarker;
  logic [BIN_W-1:0]  peakBin [PIXEL_NUM_PER_RAM];

  always_comb begin
    accept     = bus.wrEn && (state != PUBLISH);
    evtLast    = (evtIdx == EVT_W'(EVENTS_PER_PIXEL - 1));
    pixLast    = (pixIdx == PIX_W'(PIXEL_NUM_PER_RAM - 1));
    shotLast   = (shotIdx == SHOT_W'(SHOTS_PER_ACQ - 1));
    lastSample = accept && evtLast && pixLast && shotLast;
    publish    = (state == PUBLISH);
    sampleBin  = bus.data[NP-1:BIN_SHIFT];
    isMarker   = (bus.data == NO_PHOTON);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = lastSample ? PUBLISH : ACCUM;
      ACCUM:   if (lastSample) stateNext = PUBLISH;
      PUBLISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Shot-major, then pixel, then event ordering of the incoming samples.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shotIdx <= '0;
      pixIdx  <= '0;
      evtIdx  <= '0;
    end else if (publish) begin
      shotIdx <= '0;
      pixIdx  <= '0;
      evtIdx  <= '0;
    end else if (accept) begin
      evtIdx <= evtLast ? '0 : evtIdx + EVT_W'(1);
      if (evtLast) begin
        pixIdx <= pixLast ? '0 : pixIdx + PIX_W'(1);
        if (pixLast) shotIdx <= shotLast ? '0 : shotIdx + SHOT_W'(1);
      end
    end
  end

  for (genvar p = 0; p < int'(PIXEL_NUM_PER_RAM); p++) begin : gPix
    logic sampleEn;
    assign sampleEn = accept && (pixIdx == PIX_W'(p));

    his_pixel_hist #(.cntW(cntW)) uHist (
      .clk      (clk),
      .res      (res),
      .sampleEn (sampleEn),
      .bin      (sampleBin),
      .isMarker (isMarker),
      .clear    (publish),
      .peakBin  (peakBin[p])
    );
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int p = 0; p < int'(PIXEL_NUM_PER_RAM); p++) bus.peakResult[p] <= '0;
    end else if (publish) begin
      for (int p = 0; p < int'(PIXEL_NUM_PER_RAM); p++)
        bus.peakResult[p] <= {peakBin[p], {BIN_SHIFT{1'b0}}};
    end
  end

endmodule

// File: tb/tb_histogram_builder_fsm.sv
// Scoreboard bench for histogram_builder_fsm: default instance plus a 2-bit-counter instance.
module tb_histogram_builder_fsm;
  import histogram_builder_fsm_pkg::*;

  localparam int unsigned W   = NP * PIXEL_NUM_PER_RAM;
  localparam int          ACQ = PIXEL_NUM_PER_RAM * EVENTS_PER_PIXEL * SHOTS_PER_ACQ;

  typedef logic [NP-1:0] acq_t [ACQ];
  typedef struct packed {
    logic         sat;
    logic [W-1:0] exp;
  } sbEntry_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  histogram_builder_fsm_if busMain ();
  histogram_builder_fsm_if busSat ();

  histogram_builder_fsm dut (
    .clk (clk),
    .res (res),
    .bus (busMain)
  );

  histogram_builder_fsm #(.cntW(2)) dutSat (
    .clk (clk),
    .res (res),
    .bus (busSat)
  );

  logic [W-1:0] gotMain;
  logic [W-1:0] gotSat;
  always_comb begin
    for (int p = 0; p < int'(PIXEL_NUM_PER_RAM); p++) begin
      gotMain[p*NP +: NP] = busMain.peakResult[p];
      gotSat[p*NP +: NP]  = busSat.peakResult[p];
    end
  end

  int nCmp = 0;
  int nBad = 0;
  sbEntry_t sbq [$];

  localparam logic [W-1:0] EXP_ACQ = {NP'(64), NP'(992), NP'(480)};

  acq_t acq1, acq2, marks, sat64;

  function automatic logic [W-1:0] got(input bit sat);
    return sat ? gotSat : gotMain;
  endfunction

  // Independent reference: per-pixel histograms with saturation at cntMax.
  function automatic logic [W-1:0] model(input acq_t s, input int cntMax);
    int hist [PIXEL_NUM_PER_RAM][NUM_BINS];
    int maxc [PIXEL_NUM_PER_RAM];
    int pk   [PIXEL_NUM_PER_RAM];
    logic [W-1:0] r;
    for (int p = 0; p < int'(PIXEL_NUM_PER_RAM); p++) begin
      maxc[p] = 0;
      pk[p]   = 0;
      for (int b = 0; b < int'(NUM_BINS); b++) hist[p][b] = 0;
    end
    for (int i = 0; i < ACQ; i++) begin
      int p, b;
      p = (i / int'(EVENTS_PER_PIXEL)) % int'(PIXEL_NUM_PER_RAM);
      if (s[i] != NO_PHOTON) begin
        b = int'(s[i]) / (1 << BIN_SHIFT);
        if (hist[p][b] < cntMax) hist[p][b]++;
        if (hist[p][b] > maxc[p]) begin
          maxc[p] = hist[p][b];
          pk[p]   = b;
        end
      end
    end
    for (int p = 0; p < int'(PIXEL_NUM_PER_RAM); p++)
      r[p*NP +: NP] = NP'(pk[p] * (1 << BIN_SHIFT));
    return r;
  endfunction

  task automatic driveSample(input bit sat, input logic [NP-1:0] d);
    if (sat) begin busSat.wrEn = 1'b1; busSat.data = d; end
    else     begin busMain.wrEn = 1'b1; busMain.data = d; end
    @(posedge clk);
    #1;
    busSat.wrEn  = 1'b0;
    busMain.wrEn = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic popCheck(input string tag);
    sbEntry_t e;
    nCmp++;
    if (sbq.size() == 0) begin
      nBad++;
      $display("FAIL %s: scoreboard empty at publish", tag);
    end else begin
      e = sbq.pop_front();
      if (got(e.sat) !== e.exp) begin
        nBad++;
        $display("FAIL %s: peakResult got %h expected %h", tag, got(e.sat), e.exp);
      end
    end
  endtask

  // Run one acquisition; dropNext drives an extra sample into the PUBLISH cycle.
  task automatic runAcq(input bit sat, input acq_t s, input int gap, input logic [W-1:0] expv,
                        input bit dropNext, input string tag);
    logic [W-1:0] prev;
    prev = got(sat);
    for (int i = 0; i < ACQ; i++) begin
      driveSample(sat, s[i]);
      if (i == ACQ - 1) begin
        nCmp++;
        if (got(sat) !== prev) begin
          nBad++;
          $display("FAIL %s_hold: peakResult got %h expected %h", tag, got(sat), prev);
        end
      end else if (gap > 0) begin
        idleCycles(gap);
      end
    end
    sbq.push_back('{sat: sat, exp: expv});
    if (dropNext) driveSample(sat, NP'(0));
    else          idleCycles(1);
    popCheck(tag);
  endtask

  task automatic test_reset();
    nCmp++;
    if (gotMain !== '0 || gotSat !== '0) begin
      nBad++;
      $display("FAIL reset_init: peakResult got %h/%h expected 0", gotMain, gotSat);
    end
    runAcq(1'b0, acq1, 0, EXP_ACQ, 1'b0, "pre_reset_acq");
    @(negedge clk);
    #2 res = 1'b1;
    #1;
    nCmp++;
    if (gotMain !== '0) begin
      nBad++;
      $display("FAIL reset_async: peakResult got %h expected 0", gotMain);
    end
    @(negedge clk);
    res = 1'b0;
    idleCycles(1);
    for (int i = 0; i < 5; i++) driveSample(1'b0, NP'(1000));
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    idleCycles(1);
    runAcq(1'b0, acq1, 0, EXP_ACQ, 1'b0, "reset_mid_acq");
  endtask

  task automatic test_acq();
    runAcq(1'b0, acq1, 0, EXP_ACQ, 1'b0, "acq1");
    idleCycles(4);
    runAcq(1'b0, acq2, 0, EXP_ACQ, 1'b0, "acq2");
  endtask

  task automatic test_markers();
    idleCycles(1);
    runAcq(1'b0, marks, 0, '0, 1'b0, "all_markers");
  endtask

  task automatic test_gaps();
    idleCycles(1);
    runAcq(1'b0, acq1, 3, EXP_ACQ, 1'b0, "wren_gaps");
  endtask

  task automatic test_back_to_back();
    idleCycles(2);
    runAcq(1'b0, marks, 0, '0, 1'b1, "b2b_markers");
    runAcq(1'b0, acq2, 0, EXP_ACQ, 1'b1, "b2b_acq2");
    runAcq(1'b0, acq1, 0, EXP_ACQ, 1'b0, "b2b_acq1");
  endtask

  task automatic test_random();
    acq_t r;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ACQ; i++) begin
        if ($urandom_range(0, 5) == 0) r[i] = NO_PHOTON;
        else r[i] = NP'($urandom_range(0, 3) * 32 + $urandom_range(0, 31) + ((k == 3) ? 896 : 0));
      end
      idleCycles(1);
      runAcq(1'b0, r, k % 2, model(r, 255), 1'b0, "random");
    end
  endtask

  task automatic test_saturation();
    idleCycles(1);
    runAcq(1'b1, sat64, 0, {NP'(64), NP'(64), NP'(64)}, 1'b0, "saturation");
    idleCycles(1);
    runAcq(1'b1, acq1, 0, model(acq1, 3), 1'b0, "sat_acq1");
  endtask

  initial begin
    busMain.wrEn = 1'b0;
    busMain.data = '0;
    busSat.wrEn  = 1'b0;
    busSat.data  = '0;
    acq1  = '{NP'(108), NP'(511), NP'(1022), NP'(1022), NP'(200), NP'(90),
              NP'(511), NP'(1023), NP'(90), NP'(90), NP'(90), NP'(90)};
    acq2  = '{NP'(300), NP'(500), NP'(50), NP'(1000), NP'(48), NP'(90),
              NP'(600), NP'(500), NP'(1000), NP'(1023), NP'(120), NP'(90)};
    for (int i = 0; i < ACQ; i++) begin
      marks[i] = NO_PHOTON;
      sat64[i] = NP'(64);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    idleCycles(1);

    test_reset();
    test_acq();
    test_markers();
    test_gaps();
    test_back_to_back();
    test_random();
    test_saturation();

    nCmp++;
    if (sbq.size() != 0) begin
      nBad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
